// File: rtl/counter_async_4bit_async_reset_pkg.sv
// Shared counter constants for the asynchronous ripple counter.
// Build option: COUNTER_ASYNC_DOWN_EN selects down-counting.
package counter_async_4bit_async_reset_pkg;

    localparam int COUNTER_ASYNC_MAX_WIDTH = 16;

endpackage

// File: rtl/counter_async_4bit_async_reset_if.sv
// Count bus of the ripple counter.
// Master drives the count, slave observes it.
interface counter_async_4bit_async_reset_if #(
    parameter int WIDTH = 4
);

    logic [WIDTH-1:0] count_out;

    modport master (output count_out);
    modport slave  (input  count_out);

endinterface

// File: rtl/counter_async_4bit_async_reset_tff.sv
// Toggle flop with asynchronous active-low clear.
// One cell of the ripple chain.
module tff_async_reset (
    input  logic clk,
    input  logic reset_al_in,
    output logic q
);

    logic q_q;
    logic q_d;

    // next state is always the inverted current state
    always_comb begin
        q_d = ~q_q;
    end

    // toggle on every rising edge of this cell's clock
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            q_q <= 1'b0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/counter_async_4bit_async_reset.sv
// Ripple counter: stage 0 on clk, stage n on stage n-1's output.
// Build option: COUNTER_ASYNC_DOWN_EN flips each ripple clock.
module counter_async_4bit_async_reset
    import counter_async_4bit_async_reset_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic reset_al_in,
    counter_async_4bit_async_reset_if.master cnt_if
);

    if (WIDTH < 1 || WIDTH > COUNTER_ASYNC_MAX_WIDTH) begin : g_width_chk
        $error("WIDTH out of range 1..%0d", COUNTER_ASYNC_MAX_WIDTH);
    end

    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] stage_clk;

    for (genvar n = 0; n < WIDTH; n++) begin : g_stage
        if (n == 0) begin : g_lsb
            assign stage_clk[n] = clk;
        end else begin : g_ripple
`ifdef COUNTER_ASYNC_DOWN_EN
            // toggle when the lower bit rises: borrow
            assign stage_clk[n] = q[n-1];
`else
            // toggle when the lower bit falls: carry
            assign stage_clk[n] = ~q[n-1];
`endif
        end

        tff_async_reset u_tff (
            .clk         (stage_clk[n]),
            .reset_al_in (reset_al_in),
            .q           (q[n])
        );
    end

    assign cnt_if.count_out = q;

endmodule

// File: tb/tb_counter_async_4bit_async_reset.sv
// Directed bench for the 4-bit ripple counter.
// Define COUNTER_ASYNC_DOWN_EN for the down-count build.
module tb_counter_async_4bit_async_reset;

    logic clk = 1'b0;
    logic reset_al_in = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    counter_async_4bit_async_reset_if #(.WIDTH(4)) cnt_if ();

    counter_async_4bit_async_reset #(.WIDTH(4)) dut (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .cnt_if      (cnt_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0d want %0d", tag, $time, obs, exp);
        end
    endtask

    task automatic at_time(input longint t);
        if (t > longint'($time)) #(t - longint'($time));
    endtask

    function automatic logic [3:0] exp_cnt(input int k);
        logic [3:0] u;
        u = k[3:0];
`ifdef COUNTER_ASYNC_DOWN_EN
        return 4'd0 - u;
`else
        return u;
`endif
    endfunction

    initial begin
        // reset held across edges at 5 and 15
        at_time(1);
        check("rst_t1", 16'(cnt_if.count_out), 16'd0);
        at_time(10);
        check("rst_t10", 16'(cnt_if.count_out), 16'd0);
        at_time(16);
        check("rst_t16", 16'(cnt_if.count_out), 16'd0);
        at_time(20);
        reset_al_in = 1'b1;
        at_time(24);
        check("rel_t24", 16'(cnt_if.count_out), 16'd0);

        // k-th edge at 15+10k; falling edge at +5 must not change it
        for (int k = 1; k <= 60; k++) begin
            at_time(longint'(15 + 10 * k + 1));
            check("rise", 16'(cnt_if.count_out), 16'(exp_cnt(k)));
            at_time(longint'(15 + 10 * k + 6));
            check("fall", 16'(cnt_if.count_out), 16'(exp_cnt(k)));
        end

        // second run: reset in mid-count
        at_time(630);
        reset_al_in = 1'b0;
        at_time(631);
        check("rst2", 16'(cnt_if.count_out), 16'd0);
        at_time(640);
        reset_al_in = 1'b1;
        at_time(646);
        check("run2_k1", 16'(cnt_if.count_out), 16'(exp_cnt(1)));
        at_time(721);
        check("run2_k8", 16'(cnt_if.count_out), 16'(exp_cnt(8)));
        at_time(722);
        reset_al_in = 1'b0;
        at_time(723);
        check("mid_rst", 16'(cnt_if.count_out), 16'd0);
        at_time(726);
        check("mid_hold", 16'(cnt_if.count_out), 16'd0);
        at_time(730);
        reset_al_in = 1'b1;
        at_time(736);
        check("mid_rel1", 16'(cnt_if.count_out), 16'(exp_cnt(1)));
        at_time(746);
        check("mid_rel2", 16'(cnt_if.count_out), 16'(exp_cnt(2)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
